// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V integer register file and its scoreboard.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/rv_sb_popcnt.sv
// Combinational population count of the scoreboard vector.
module rv_sb_popcnt #(
  parameter int N  = 32,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec_i,
  output logic [OW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) cnt_o = cnt_o + OW'(vec_i[i]);
  end
endmodule

// File: rtl/rv_regfile_sb.sv
// NRD-read / 2-write integer register file with x0 tied to zero, optional
// same-cycle write bypass and a per-register busy scoreboard.
module rv_regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          we,
  input  logic [2*AW-1:0]     wa,
  input  logic [2*XLEN-1:0]   wd,
  input  logic [1:0]          wb_clr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic [1:0][AW-1:0]        wa_a;
  logic [1:0][XLEN-1:0]      wd_a;
  logic [1:0]                wr_ok;

  assign wa_a = wa;
  assign wd_a = wd;

  for (genvar k = 0; k < 2; k++) begin : g_wok
    assign wr_ok[k] = we[k] && (wa_a[k] != AW'(ZERO_REG));
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      if (wr_ok[0]) regs_q[wa_a[0]] <= wd_a[0];
      if (wr_ok[1]) regs_q[wa_a[1]] <= wd_a[1];
    end
  end

  // Issue is applied after clear so a same-edge issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < 2; k++)
        if (we[k] && wb_clr[k] && (wa_a[k] == AW'(r))) busy_d[r] = 1'b0;
      if (iss_en && (iss_addr == AW'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  rv_sb_popcnt #(.N(NREG), .OW(AW + 1)) u_popcnt (
    .vec_i (busy_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rv = regs_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < 2; k++)
          if (wr_ok[k] && (wa_a[k] == ra)) rv = wd_a[k];
      end
      if (!rst) rv = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = rv;
    assign rd_busy[i]              = rst & busy_q[ra];
  end
endmodule
